// File: rtl/div_pkg.sv
// Shared encodings for the iterative RV32M divider: op codes, FSM states and counter sizing.
package div_pkg;

  localparam int unsigned DIV_DATA_WIDTH = 32;

  // funct3[1:0] of DIV/DIVU/REM/REMU
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  function automatic int unsigned div_cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  localparam int unsigned DIV_CNT_WIDTH = div_cnt_width(DIV_DATA_WIDTH);

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Build option DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic                  annul_i,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int unsigned CntW = div_cnt_width(DATA_WIDTH);

  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic                  is_rem_q, is_rem_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  // Operand decode for a launch in IDLE
  logic                  in_signed, in_rem, a_neg, b_neg, div_zero, sgn_ovf;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    in_signed = (op_i == DIV_OP_DIV) || (op_i == DIV_OP_REM);
    in_rem    = (op_i == DIV_OP_REM) || (op_i == DIV_OP_REMU);
    a_neg     = in_signed & dividend_i[DATA_WIDTH-1];
    b_neg     = in_signed & divisor_i[DATA_WIDTH-1];
    a_mag     = a_neg ? (~dividend_i + 1'b1) : dividend_i;
    b_mag     = b_neg ? (~divisor_i + 1'b1) : divisor_i;
    div_zero  = (divisor_i == '0);
    sgn_ovf   = in_signed && (dividend_i == {1'b1, {(DATA_WIDTH-1){1'b0}}}) &&
                (divisor_i == '1);
  end

  // One restoring step; the MSB of the (W+1)-bit trial difference is the borrow
  logic [DATA_WIDTH:0]   trial;
  logic [DATA_WIDTH-1:0] rem_step, quo_step, quo_fix, rem_fix;

  always_comb begin
    trial    = {rem_q, quo_q[DATA_WIDTH-1]} - {1'b0, dvs_q};
    quo_step = {quo_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
    rem_step = trial[DATA_WIDTH] ? {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]}
                                 : trial[DATA_WIDTH-1:0];
    quo_fix  = neg_quo_q ? (~quo_step + 1'b1) : quo_step;
    rem_fix  = neg_rem_q ? (~rem_step + 1'b1) : rem_step;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          is_rem_d  = in_rem;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dvs_d     = b_mag;
          rem_d     = '0;
          quo_d     = a_mag;
          if (div_zero) begin
            result_d = in_rem ? dividend_i : '1;
            state_d  = DIV_DONE;
          end else if (sgn_ovf) begin
            result_d = in_rem ? '0 : dividend_i;
            state_d  = DIV_DONE;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (a_mag < b_mag) begin
            result_d = in_rem ? dividend_i : '0;
            state_d  = DIV_DONE;
          end
`endif
          else begin
            cnt_d   = CntW'(DATA_WIDTH);
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          result_d = is_rem_q ? rem_fix : quo_fix;
          state_d  = DIV_DONE;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase

    // Flush wins over everything, including a launch or the final step
    if (annul_i) begin
      state_d  = DIV_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign busy_o   = (state_q != DIV_IDLE);
  assign ready_o  = (state_q == DIV_DONE) && !annul_i;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, special cases, flush and reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic        annul;
  logic        busy, ready;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int EarlyLat = 1;
`else
  localparam int EarlyLat = 33;
`endif

  div_unit #(.DATA_WIDTH(32)) u_dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .start_i    (start),
    .op_i       (op),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .annul_i    (annul),
    .busy_o     (busy),
    .ready_o    (ready),
    .result_o   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, wait (bounded) for ready, check latency, result and busy span
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int busy_cnt;
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!ready && lat < 100) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    if (busy) busy_cnt++;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, result, exp_res);
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
    tick();
    check({tag, " idle after"}, {30'd0, busy, ready}, 32'd0);
  endtask

  initial begin
    int rdy_cnt;
    rst_n    = 1'b0;
    start    = 1'b0;
    op       = 2'b00;
    dividend = '0;
    divisor  = '0;
    annul    = 1'b0;
    tick();
    tick();
    check("reset outputs", {busy, ready, result[29:0]}, 32'd0);
    check("reset result", result, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
    run_op("div -7/2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem -7/2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("div 7/-2",   2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem 7/-2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("divu big",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("remu big",   2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("divu 5/0",   2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem 5/0",    2'b10, 32'd5, 32'd0, 32'd5, 1);
    run_op("div ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu 3/10",  2'b01, 32'd3, 32'd10, 32'd0, EarlyLat);
    run_op("remu 3/10",  2'b11, 32'd3, 32'd10, 32'd3, EarlyLat);

    // Flush mid-CALC at N+10: idle at N+11, no ready, restart at N+12 works
    op = 2'b01; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    tick();
    start   = 1'b0;
    rdy_cnt = 0;
    for (int i = 1; i < 10; i++) begin
      if (ready) rdy_cnt++;
      tick();
    end
    annul = 1'b1;
    #1;
    if (ready) rdy_cnt++;
    tick();
    annul = 1'b0;
    check("annul idle N+11", {30'd0, busy, ready}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (ready) rdy_cnt++;
      if (i == 0) begin
        check("annul result held", result, 32'd3);
      end
      tick();
    end
    check("annul no ready", 32'(rdy_cnt), 32'd0);
    run_op("divu 1000/3", 2'b01, 32'd1000, 32'd3, 32'd333, 33);

    // Flush coinciding with the final step: no DONE, result unchanged
    op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 32; i++) tick();
    annul = 1'b1;
    tick();
    annul = 1'b0;
    check("annul last step idle", {30'd0, busy, ready}, 32'd0);
    check("annul last step result", result, 32'd333);

    // Flush during DONE suppresses the pulse
    op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 33; i++) tick();
    annul = 1'b1;
    #1;
    check("annul in done ready", {31'd0, ready}, 32'd0);
    tick();
    annul = 1'b0;
    check("annul in done idle", {31'd0, busy}, 32'd0);

    // Reset at N+20 clears everything at N+21
    op = 2'b01; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    rst_n = 1'b0;
    tick();
    check("midreset flags", {30'd0, busy, ready}, 32'd0);
    check("midreset result", result, 32'd0);
    rst_n = 1'b1;
    tick();

    // start held through the whole operation gives exactly one ready pulse
    op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 34; i++) begin
      tick();
      if (ready) begin
        rdy_cnt++;
        check("held start result", result, 32'd14);
        start = 1'b0;
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ready) rdy_cnt++;
    end
    check("held start one ready", 32'(rdy_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU.
- Sits beside the execute stage: exe launches an operation, holds its stall request while busy, and consumes the result when ready_o pulses.
- pipe_ctrl's jump flush annuls any in-flight operation.
- Replaces a single-cycle combinational divider that would break the exe timing path.

Parameters:
- DATA_WIDTH, 32, operand/result width; counter width is clog2(DATA_WIDTH)+1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- start_i  in  1  launch request from exe; sampled only in IDLE.
- op_i  in  2  instruction funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend_i  in  DATA_WIDTH  rs1 value; sampled with start_i.
- divisor_i  in  DATA_WIDTH  rs2 value; sampled with start_i.
- annul_i  in  1  flush from pipe_ctrl; aborts any operation.
- busy_o  out  1  high in CALC and DONE; exe ORs it into its stall request.
- ready_o  out  1  single-cycle pulse; result_o is valid in that cycle.
- result_o  out  DATA_WIDTH  quotient or remainder, as selected by op_i.

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - state=IDLE; busy_o=0; ready_o=0; result_o=0; counter=0.
  - Reset overrides all other inputs, including mid-CALC.
- States:
  - IDLE: when start_i=1 and annul_i=0, latch op, operands and sign flags.
    - Divisor==0 or signed overflow: go to DONE.
    - Otherwise: go to CALC with counter=DATA_WIDTH.
  - CALC: one restoring step per cycle on magnitudes.
    - Shift {rem,quo} left by 1.
    - Trial-subtract |divisor|; if there is no borrow, keep the difference and set quo[0]=1.
    - Decrement counter; at counter==1 go to DONE.
  - DONE:
    - Register result_o after sign fixup: quotient negated if sign(dividend)^sign(divisor) for DIV; remainder negated if the dividend is negative for REM.
    - ready_o=1 for exactly this cycle; next state is IDLE unconditionally.
- Latency: start_i in cycle N gives ready_o in cycle N+DATA_WIDTH+1 (33 for 32-bit). Special cases give ready_o in cycle N+1.
- result_o holds its value after DONE until the next DONE or reset.
- start_i is ignored in CALC and DONE; exe keeps it asserted while stalled without relaunching.
- Special cases (RISC-V mandated, no trap):
  - Divide by zero: quotient=all ones; remainder=dividend.
  - DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF: quotient=0x80000000; remainder=0.
- annul_i=1 in any state: next state is IDLE and ready_o is suppressed that cycle. This applies even if annul_i and the DONE transition coincide. annul_i beats a simultaneous start_i in IDLE.
- Unsigned ops (01, 11) skip absolute value and sign fixup.
- Arithmetic: the trial subtract is DATA_WIDTH+1 bits wide, and its MSB is the borrow. Magnitude of 0x80000000 is 0x80000000 as unsigned (no overflow).

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |dividend| < |divisor| (unsigned magnitude compare), go directly to DONE with quotient=0 and remainder=dividend; ready_o at N+1.
- Undefined: such operands take the full CALC path with identical results, latency N+DATA_WIDTH+1.

Decomposition:
- Package div_pkg:
  - op encodings DIV_OP_DIV/DIVU/REM/REMU;
  - state encoding DIV_IDLE/DIV_CALC/DIV_DONE;
  - DIV_CNT_WIDTH.
  - Add op and state entries to defines.v for consistency with the pipeline.
- Sub-module: none needed. The datapath (abs, step, fixup) stays in one module of about 200 lines; a separate step cell adds no reuse.

Test Plan:
- DIVU 100/7 → busy_o high for 33 cycles; ready_o at N+33; result 14. REMU same operands → 2.
- DIV 0xFFFFFFF9 (−7)/2 → 0xFFFFFFFD (−3). REM same operands → 0xFFFFFFFF (−1). Both have remainder sign = dividend sign.
- Divide by zero:
  - DIVU 5/0 → 0xFFFFFFFF at N+1.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 at N+1.
  - REM same operands → 0.
- Annul: start DIVU 1000/3, assert annul_i at cycle N+10 → IDLE at N+11; no ready_o ever; new start at N+12 computes correctly.
- Reset and restart:
  - rst_i=0 at N+20 of an operation → next cycle all outputs 0, state IDLE.
  - start_i held high through CALC → exactly one ready_o.
- DIV_EARLY_OUT_EN: DIVU 3/10 → result 0 at N+1 when defined, at N+33 when undefined. REMU same operands → 3 in both builds.
